mult_share_arb: RTL and testbench
=================================

// Module: mult_share_arb
// PURPOSE
//  Round-robin controller sharing one sequential multiplier (data_rdy/result_rdy
//  handshake) among NREQ requesters. Selects a requester, launches its operands,
//  waits for the result and returns it tagged to that requester.
//  Sits between client blocks and the single multiplier instance.
// PARAMETERS
//  NREQ     4   number of requesters (>=2)
//  N        8   width of operand a (mult1)
//  M        8   width of operand b (mult2)
//  TIMEOUT  64  max cycles in WAIT for m_result_rdy before abort (>=2)
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         synchronous reset, active-high
//  req           in   NREQ      per-requester request level
//  a_bus         in   NREQ*N    operand a; requester i at [i*N +: N]
//  b_bus         in   NREQ*M    operand b; requester i at [i*M +: M]
//  gnt           out  NREQ      one-hot 1-cycle pulse: operands of i latched
//  done          out  NREQ      one-hot 1-cycle pulse: res_out valid for i
//  res_out       out  N+M       product, valid only while done!=0
//  timeout_err   out  1         1-cycle pulse with done on aborted op
//  busy          out  1         1 whenever state != IDLE
//  m_data_rdy    out  1         launch pulse to multiplier
//  m_mult1       out  N         operand a to multiplier
//  m_mult2       out  M         operand b to multiplier
//  m_result_rdy  in   1         multiplier result valid
//  m_result      in   N+M       multiplier product
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; RR pointer = NREQ-1 (req[0] wins first).
//  - All outputs registered. FSM: IDLE -> ISSUE -> WAIT -> DONE -> DRAIN -> IDLE.
//  - IDLE: if |req, pick first set bit searching from pointer+1 (wrap mod NREQ);
//    latch its a/b into m_mult1/m_mult2, store index, pointer <= index. Next cycle
//    is ISSUE. No req: stay IDLE.
//  - ISSUE (1 cycle): m_data_rdy=1, gnt[idx]=1. m_mult1/2 held until next grant.
//  - WAIT: m_data_rdy=0; cycle counter runs from 0. m_result_rdy sampled 1 ->
//    capture m_result, go DONE. Counter reaches TIMEOUT-1 without it -> go DONE
//    with res_out=0 and timeout_err=1.
//  - DONE (1 cycle): done[idx]=1, res_out valid, timeout_err as above.
//  - DRAIN: wait until m_result_rdy==0 (stay while 1), then IDLE. If already 0,
//    DRAIN lasts 1 cycle. Guarantees no launch while multiplier shows old result.
//  - Latency: req sampled in IDLE at cycle t -> gnt/m_data_rdy at t+1; done
//    exactly 2 cycles after first cycle m_result_rdy is seen high.
//  - Requester holds req and operands until gnt; req dropped before selection is
//    ignored (no op). req still high after done is a new request, arbitrated
//    normally (RR: others pending are served first).
//  - req changes during ISSUE..DRAIN have no effect on the operation in flight.
//  - Product width N+M, unsigned, no truncation; res_out passed through unchanged.
//  - rst at any state: next cycle IDLE, all outputs 0, in-flight op dropped
//    without done; multiplier reset together with this block.
//  - gnt, done, timeout_err never asserted in same cycle as another gnt/done.
// TESTING (real multiplier, NREQ=4, N=M=8, TIMEOUT=64 unless stated)
//  1 req[0] alone, a=25 b=5 -> gnt[0] 1 cycle later, done[0] with res_out=125,
//    other done bits 0, busy low again after DRAIN.
//  2 after reset req=4'b1111 held, a_i=i+2, b_i=10 -> done order 0,1,2,3 with
//    results 20,30,40,50; one op in flight at a time (m_data_rdy pulses 4).
//  3 req[0] and req[2] held for 6 ops, a=12 b=12 -> gnt order 0,2,0,2,0,2;
//    each res_out=144; req[1],req[3] never granted.
//  4 stub multiplier never raises m_result_rdy -> done[idx] and timeout_err
//    exactly 64 WAIT cycles after ISSUE, res_out=0; next request then completes.
//  5 stub holds m_result_rdy high 5 cycles -> one done only; FSM stays DRAIN until
//    it falls; pending req[1] gets gnt only after m_result_rdy==0.
//  6 rst pulsed 1 cycle during WAIT -> next cycle all outputs 0, no done; then
//    req[3] a=255 b=255 -> done[3], res_out=65025 (first pick after reset = 3 only
//    because it is the sole requester).

Source files
------------

// File: rtl/mult_share_arb_if.sv
// Bundle of requester-side and multiplier-side signals around the shared-multiplier arbiter.
// The arbiter uses the master view; clients and the multiplier use the slave view.
interface mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int N    = 8,
  parameter int M    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_bus;
  logic [NREQ*M-1:0] b_bus;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [N+M-1:0]    res_out;
  logic              timeout_err;
  logic              busy;
  logic              m_data_rdy;
  logic [N-1:0]      m_mult1;
  logic [M-1:0]      m_mult2;
  logic              m_result_rdy;
  logic [N+M-1:0]    m_result;

  modport master (
    input  req, a_bus, b_bus, m_result_rdy, m_result,
    output gnt, done, res_out, timeout_err, busy, m_data_rdy, m_mult1, m_mult2
  );

  modport slave (
    output req, a_bus, b_bus, m_result_rdy, m_result,
    input  gnt, done, res_out, timeout_err, busy, m_data_rdy, m_mult1, m_mult2
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin controller that time-shares one sequential multiplier among NREQ
// requesters: pick, launch, wait (with timeout), return the tagged result, drain.
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int N       = 8,
  parameter int M       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  mult_share_arb_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int P  = N + M;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [IW-1:0]   pick;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            vld_p0;
  logic [P-1:0]    res_p0;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic [P-1:0]    res_nxt;
  logic            terr_nxt, busy_nxt, mdr_nxt;
  logic [N-1:0]    m1_nxt;
  logic [M-1:0]    m2_nxt;

  // First requester at or after p+1, wrapping; only meaningful when |r.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
    logic [IW-1:0] sel;
    logic          hit;
    int            c;
    sel = p;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(p) + k) % NREQ;
      if (!hit && r[IW'(c)]) begin
        hit = 1'b1;
        sel = IW'(c);
      end
    end
    return sel;
  endfunction

  // Stage p0: input register on the multiplier return path
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= bus.m_result_rdy;
  end

  always_ff @(posedge clk) begin
    res_p0 <= bus.m_result;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    done_nxt  = '0;
    res_nxt   = '0;
    terr_nxt  = 1'b0;
    mdr_nxt   = 1'b0;
    m1_nxt    = bus.m_mult1;
    m2_nxt    = bus.m_mult2;
    pick      = rr_pick(bus.req, ptr);

    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = ISSUE;
          idx_nxt   = pick;
          ptr_nxt   = pick;
          m1_nxt    = bus.a_bus[int'(pick)*N +: N];
          m2_nxt    = bus.b_bus[int'(pick)*M +: M];
          gnt_nxt   = NREQ'(1) << pick;
          mdr_nxt   = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (vld_p0) begin
          state_nxt = DONE;
          done_nxt  = NREQ'(1) << idx;
          res_nxt   = res_p0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // Abort: report completion with a zero product so the client is released.
          state_nxt = DONE;
          done_nxt  = NREQ'(1) << idx;
          terr_nxt  = 1'b1;
        end
      end
      DONE:    state_nxt = DRAIN;
      // Hold off the next launch until the multiplier has dropped its old result.
      DRAIN:   if (!vld_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= IW'(NREQ - 1);
      idx             <= '0;
      cnt             <= '0;
      bus.gnt         <= '0;
      bus.done        <= '0;
      bus.res_out     <= '0;
      bus.timeout_err <= 1'b0;
      bus.busy        <= 1'b0;
      bus.m_data_rdy  <= 1'b0;
      bus.m_mult1     <= '0;
      bus.m_mult2     <= '0;
    end else begin
      state           <= state_nxt;
      ptr             <= ptr_nxt;
      idx             <= idx_nxt;
      cnt             <= cnt_nxt;
      bus.gnt         <= gnt_nxt;
      bus.done        <= done_nxt;
      bus.res_out     <= res_nxt;
      bus.timeout_err <= terr_nxt;
      bus.busy        <= busy_nxt;
      bus.m_data_rdy  <= mdr_nxt;
      bus.m_mult1     <= m1_nxt;
      bus.m_mult2     <= m2_nxt;
    end
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural sequential multiplier that
// can also act as a never-responding or long-holding stub.
module tb_mult_share_arb;
  localparam int NREQ = 4, N = 8, M = 8, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_share_arb_if #(.NREQ(NREQ), .N(N), .M(M)) bus ();

  mult_share_arb #(.NREQ(NREQ), .N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Multiplier model: result 4 cycles after launch, held for rdy_len cycles.
  logic       stub_never;
  int         rdy_len;
  logic [7:0] ma, mb;
  int         mcnt, hold;

  always @(posedge clk) begin
    if (rst) begin
      bus.m_result_rdy <= 1'b0;
      bus.m_result     <= '0;
      mcnt             <= 0;
      hold             <= 0;
    end else if (bus.m_data_rdy) begin
      ma               <= bus.m_mult1;
      mb               <= bus.m_mult2;
      mcnt             <= 3;
      bus.m_result_rdy <= 1'b0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !stub_never) begin
        bus.m_result_rdy <= 1'b1;
        bus.m_result     <= 16'(ma) * 16'(mb);
        hold             <= rdy_len - 1;
      end
    end else if (bus.m_result_rdy) begin
      if (hold != 0) hold <= hold - 1;
      else begin
        bus.m_result_rdy <= 1'b0;
        bus.m_result     <= '0;
      end
    end
  end

  int errors, checks, cyc, launches, done_cnt, rdy_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.m_data_rdy) launches++;
    if (bus.done != '0) done_cnt++;
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (bus.gnt == '0 && n < 200);
    chk({tag, " gnt_seen"}, 32'(bus.gnt != '0), 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    rdy_cyc = -1;
    do begin
      step(); n++;
      if (bus.m_result_rdy && rdy_cyc < 0) rdy_cyc = cyc;
    end while (bus.done == '0 && n < 200);
    chk({tag, " done_seen"}, 32'(bus.done != '0), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (bus.busy && n < 50);
    chk({tag, " idle"}, 32'(bus.busy), 0);
  endtask

  int g, d0, last_hi, n5, first_res, l0;

  initial begin
    errors = 0; checks = 0; cyc = 0; launches = 0; done_cnt = 0; rdy_cyc = -1;
    stub_never = 1'b0; rdy_len = 1;
    bus.req = '0; bus.a_bus = '0; bus.b_bus = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst gnt", 32'(bus.gnt), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst res_out", 32'(bus.res_out), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst m_data_rdy", 32'(bus.m_data_rdy), 0);
    chk("rst timeout_err", 32'(bus.timeout_err), 0);
    chk("rst m_mult1", 32'(bus.m_mult1), 0);
    rst = 1'b0;
    step();

    // 1: single requester, gnt one cycle after sampling, done 2 cycles after rdy
    bus.req = 4'b0001; bus.a_bus[7:0] = 8'd25; bus.b_bus[7:0] = 8'd5;
    step();
    chk("t1 gnt", 32'(bus.gnt), 1);
    chk("t1 m_data_rdy", 32'(bus.m_data_rdy), 1);
    chk("t1 m_mult1", 32'(bus.m_mult1), 25);
    chk("t1 m_mult2", 32'(bus.m_mult2), 5);
    bus.req = '0;
    wait_done("t1");
    chk("t1 done", 32'(bus.done), 1);
    chk("t1 res_out", 32'(bus.res_out), 125);
    chk("t1 timeout_err", 32'(bus.timeout_err), 0);
    chk("t1 rdy_to_done", 32'(cyc - rdy_cyc), 2);
    step();
    chk("t1 done_pulse", 32'(bus.done), 0);
    wait_idle("t1");

    // 2: all four requesting after reset, served 0..3, one op in flight
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b1111;
    bus.a_bus = {8'd5, 8'd4, 8'd3, 8'd2};
    bus.b_bus = {4{8'd10}};
    launches = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("t2");
      chk("t2 gnt", 32'(bus.gnt), 32'(1) << k);
      bus.req[k] = 1'b0;
      l0 = launches;
      wait_done("t2");
      chk("t2 done", 32'(bus.done), 32'(1) << k);
      chk("t2 res_out", 32'(bus.res_out), 32'((k + 2) * 10));
      chk("t2 single_flight", 32'(launches), 32'(l0));
    end
    wait_idle("t2");
    chk("t2 launches", 32'(launches), 4);

    // 3: req[0] and req[2] held, alternating service
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b0101;
    bus.a_bus = {4{8'd12}};
    bus.b_bus = {4{8'd12}};
    for (int k = 0; k < 6; k++) begin
      wait_gnt("t3");
      chk("t3 gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'd1 : 32'd4);
      wait_done("t3");
      chk("t3 done", 32'(bus.done), (k % 2 == 0) ? 32'd1 : 32'd4);
      chk("t3 res_out", 32'(bus.res_out), 144);
      if (k == 5) bus.req = '0;
    end
    wait_idle("t3");

    // 4: multiplier never answers -> abort after 64 WAIT cycles (done in the 65th cycle after ISSUE)
    stub_never = 1'b1;
    bus.req = 4'b0010; bus.a_bus[15:8] = 8'd3; bus.b_bus[15:8] = 8'd7;
    wait_gnt("t4");
    g = cyc;
    bus.req = '0;
    wait_done("t4");
    chk("t4 abort_latency", 32'(cyc - g), 65);
    chk("t4 done", 32'(bus.done), 2);
    chk("t4 timeout_err", 32'(bus.timeout_err), 1);
    chk("t4 res_out", 32'(bus.res_out), 0);
    step();
    chk("t4 terr_pulse", 32'(bus.timeout_err), 0);
    stub_never = 1'b0;
    wait_idle("t4a");
    bus.req = 4'b0010;
    wait_gnt("t4b");
    bus.req = '0;
    wait_done("t4b");
    chk("t4 recover_res", 32'(bus.res_out), 21);
    chk("t4 recover_terr", 32'(bus.timeout_err), 0);
    wait_idle("t4b");

    // 5: result held high 5 cycles; pending req[1] only after it falls
    rdy_len = 5;
    bus.req = 4'b0001; bus.a_bus[7:0] = 8'd2; bus.b_bus[7:0] = 8'd3;
    wait_gnt("t5");
    chk("t5 gnt0", 32'(bus.gnt), 1);
    bus.req = 4'b0010; bus.a_bus[15:8] = 8'd4; bus.b_bus[15:8] = 8'd5;
    d0 = done_cnt; last_hi = -1; n5 = 0; first_res = -1;
    do begin
      step(); n5++;
      if (bus.m_result_rdy) last_hi = cyc;
      if (bus.done[0]) first_res = int'(bus.res_out);
    end while (bus.gnt == '0 && n5 < 100);
    chk("t5 gnt1", 32'(bus.gnt), 2);
    chk("t5 one_done", 32'(done_cnt - d0), 1);
    chk("t5 first_res", 32'(first_res), 6);
    chk("t5 gnt_after_rdy_low", 32'(last_hi >= 0 && cyc > last_hi), 1);
    chk("t5 rdy_low_at_gnt", 32'(bus.m_result_rdy), 0);
    bus.req = '0;
    wait_done("t5b");
    chk("t5 done1", 32'(bus.done), 2);
    chk("t5 res1", 32'(bus.res_out), 20);
    rdy_len = 1;
    wait_idle("t5");

    // 6: reset during WAIT drops the op; then req[3] alone
    bus.req = 4'b0100; bus.a_bus[23:16] = 8'd9; bus.b_bus[23:16] = 8'd9;
    wait_gnt("t6");
    bus.req = '0;
    step(); step();
    rst = 1'b1;
    step();
    chk("t6 rst gnt", 32'(bus.gnt), 0);
    chk("t6 rst done", 32'(bus.done), 0);
    chk("t6 rst res_out", 32'(bus.res_out), 0);
    chk("t6 rst busy", 32'(bus.busy), 0);
    chk("t6 rst m_mult1", 32'(bus.m_mult1), 0);
    chk("t6 rst m_mult2", 32'(bus.m_mult2), 0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (10) step();
    chk("t6 no_done", 32'(done_cnt - d0), 0);
    bus.req = 4'b1000; bus.a_bus[31:24] = 8'd255; bus.b_bus[31:24] = 8'd255;
    wait_gnt("t6b");
    chk("t6 gnt3", 32'(bus.gnt), 8);
    bus.req = '0;
    wait_done("t6b");
    chk("t6 done3", 32'(bus.done), 8);
    chk("t6 res_out", 32'(bus.res_out), 65025);
    wait_idle("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
